maze_loader: RTL
================

Name: maze_loader

Overview:
- Upstream stage of the rat-in-maze solver.
- Accepts the maze one row per beat over a valid/ready stream.
- Serialises each row into single-bit writes on the maze memory's write port (loc/dIn/wr).
- When the whole maze is stored, pulses the solver's start input, so the solver always begins on a fully loaded maze.

Parameters:
- ROWS, 16, number of maze rows.
- COLS, 16, number of maze columns; also the in_data width.
- ADDR_W, 8, memory address width; must satisfy ROWS*COLS <= 2**ADDR_W.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- load_start  input  1  request a new load; sampled only in IDLE.
- in_valid  input  1  row beat valid.
- in_data  input  COLS  row bits; bit c = column c; 1 = wall, 0 = open.
- in_ready  output  1  loader can take a row beat.
- mem_loc  output  ADDR_W  write address = row*COLS + col.
- mem_din  output  1  cell bit being written.
- mem_wr  output  1  write strobe, one cell per cycle.
- busy  output  1  high whenever state != IDLE.
- load_done  output  1  one-cycle pulse at end of load.
- solve_start  output  1  one-cycle pulse to the solver start input; coincides with load_done.
- load_err  output  1  entry/exit check failure, sticky (see Optional Feature).

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; row=0; col=0; shift register=0.
  - All outputs 0, including load_err.
- Reset mid-load: returns to IDLE immediately.
  - Already-written memory cells are not rolled back.
  - No load_done or solve_start is issued.
- FSM states: IDLE, ACCEPT, WRITE, FINISH.
- IDLE:
  - in_ready=0.
  - load_start=1 -> ACCEPT; row=0; load_err cleared.
- ACCEPT:
  - in_ready=1.
  - Transfer occurs only when in_valid && in_ready.
  - On transfer: in_data is latched into the shift register, col=0, next state WRITE.
  - If in_valid is low, the FSM waits indefinitely.
- WRITE:
  - in_ready=0; mem_wr=1; mem_loc=row*COLS+col; mem_din=shift[0].
  - Each cycle: shift right by 1, col+1.
  - At col==COLS-1:
    - if row==ROWS-1 -> FINISH;
    - else row+1 -> ACCEPT.
- FINISH:
  - load_done=1 and solve_start=1 for exactly one cycle.
  - Next state IDLE.
- Timing:
  - Per row: 1 accept cycle (minimum) + COLS write cycles.
  - Minimum full load = ROWS*(COLS+1)+1 cycles: 273 at the defaults, counted from the first ACCEPT cycle to the FINISH cycle inclusive.
- Width rules:
  - row and col counters are clog2-sized.
  - mem_loc is the zero-extended product, truncated to ADDR_W.
  - No wrap occurs, because counters stop at their limits.
- load_start outside IDLE is ignored; a pending in_valid outside ACCEPT is not consumed.
- Outputs are registered or decoded from state; mem_* are valid in the same cycle as mem_wr.

Optional Feature:
- Macro: MAZE_LOADER_OPEN_CHECK_EN.
- With the macro defined:
  - Loader records a flag if row 0 bit 0 (entry cell 0) == 1 or row ROWS-1 bit COLS-1 (exit cell ROWS*COLS-1) == 1.
  - All cells are still written.
  - In FINISH, if the flag is set: load_done pulses, solve_start stays 0, and load_err is set and held until the next accepted load_start or rst.
- Without the macro: load_err is tied 0 and solve_start always pulses in FINISH.

Decomposition:
- Shared package maze_pkg holds:
  - constants MAZE_ROWS=16, MAZE_COLS=16, MAZE_ADDR_W=8;
  - CELL_WALL=1'b1 and CELL_OPEN=1'b0;
  - loader state enum type.
- One natural sub-module, maze_row_serializer: shift register plus column counter, emitting bit/col/last_col.

Test Plan:
- Reset mid-WRITE (rst during row 3, col 5) -> next cycle busy=0, mem_wr=0, in_ready=0; no load_done.
- Full load, in_valid held high, rows = 16'hA5A5 alternating with 16'h0000 -> 256 writes, mem_loc 0..255 in order; mem_din at loc 0 = 1, at loc 1 = 0; load_done and solve_start high together for one cycle at cycle 273.
- Backpressure: in_valid dropped for 10 cycles before row 7 -> loader waits in ACCEPT with in_ready=1, total 283 cycles, data at loc 112..127 correct.
- load_start pulsed during WRITE -> ignored; exactly one load_done.
- With MAZE_LOADER_OPEN_CHECK_EN: row 15 = 16'h8000 -> load_done=1, solve_start=0, load_err=1 held; next load_start clears load_err.
- Without the macro, same stimulus -> solve_start pulses, load_err=0.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared definitions for the maze front end: default geometry, cell encoding,
// loader FSM states and a counter-width helper.
package maze_pkg;

    localparam int MAZE_ROWS   = 16;
    localparam int MAZE_COLS   = 16;
    localparam int MAZE_ADDR_W = 8;

    localparam logic CELL_WALL = 1'b1;
    localparam logic CELL_OPEN = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
        ST_FINISH
    } loader_state_t;

    // Width of a counter that must hold 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/maze_row_serializer.sv
// Row serializer: holds one maze row and presents it LSB first, one column per
// advance, together with the column index and a last-column flag.
// Requires COLS >= 2.
module maze_row_serializer
    import maze_pkg::*;
#(
    parameter int COLS  = MAZE_COLS,
    parameter int COL_W = cnt_width(COLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [COLS-1:0]  data,
    input  logic             advance,
    output logic             bit_out,
    output logic [COL_W-1:0] col,
    output logic             last_col
);

    logic [COLS-1:0] shift;

    // Shift register and column counter: load restarts the row, advance steps one cell.
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            shift <= '0;
            col   <= '0;
        end else if (load) begin
            shift <= data;
            col   <= '0;
        end else if (advance) begin
            shift <= {CELL_OPEN, shift[COLS-1:1]};
            // The column counter parks at its limit instead of wrapping.
            if (!last_col) begin
                col <= col + 1'b1;
            end
        end
    end

    assign bit_out  = shift[0];
    assign last_col = (col == COL_W'(COLS - 1));

endmodule

// File: rtl/maze_loader.sv
// Maze loader: accepts the maze one row per valid/ready beat, writes it into
// the maze memory one cell per cycle, then pulses the solver start.
// Optional build macro: MAZE_LOADER_OPEN_CHECK_EN -- flags a walled entry
// (cell 0) or exit (cell ROWS*COLS-1), suppresses solve_start and raises a
// sticky load_err. Without it load_err is tied low.
module maze_loader
    import maze_pkg::*;
#(
    parameter int ROWS   = MAZE_ROWS,
    parameter int COLS   = MAZE_COLS,
    parameter int ADDR_W = MAZE_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [COLS-1:0]   in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_loc,
    output logic              mem_din,
    output logic              mem_wr,
    output logic              busy,
    output logic              load_done,
    output logic              solve_start,
    output logic              load_err
);

    localparam int ROW_W  = cnt_width(ROWS);
    localparam int COL_W  = cnt_width(COLS);
    localparam int PROD_W = ADDR_W + ROW_W + COL_W;

    loader_state_t    state, state_nxt;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             cell_bit;
    logic             last_col;
    logic             last_row;
    logic             take;
    logic             in_write;
    logic             start_ok;
    logic [PROD_W-1:0] loc_wide;

    assign in_write = (state == ST_WRITE);
    assign take     = (state == ST_ACCEPT) && in_valid;
    assign start_ok = (state == ST_IDLE) && load_start;
    assign last_row = (row == ROW_W'(ROWS - 1));

    maze_row_serializer #(
        .COLS  (COLS),
        .COL_W (COL_W)
    ) u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (take),
        .data     (in_data),
        .advance  (in_write),
        .bit_out  (cell_bit),
        .col      (col),
        .last_col (last_col)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: the default assignment first guarantees no latch on paths the case leaves untouched.
        state_nxt = state;
        case (state)
            ST_IDLE:   if (load_start) state_nxt = ST_ACCEPT;
            ST_ACCEPT: if (in_valid)   state_nxt = ST_WRITE;
            ST_WRITE:  if (last_col)   state_nxt = last_row ? ST_FINISH : ST_ACCEPT;
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Row counter: cleared on a new load, stepped after each row's last cell, parks at ROWS-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            row <= '0;
        end else if (start_ok) begin
            row <= '0;
        end else if (in_write && last_col && !last_row) begin
            row <= row + 1'b1;
        end
    end

    // Cell address: zero-extended row*COLS+col, truncated to the memory width.
    assign loc_wide = PROD_W'(row) * PROD_W'(COLS) + PROD_W'(col);

    assign in_ready  = (state == ST_ACCEPT);
    assign busy      = (state != ST_IDLE);
    assign mem_wr    = in_write;
    assign mem_loc   = in_write ? loc_wide[ADDR_W-1:0] : '0;
    assign mem_din   = in_write & cell_bit;
    assign load_done = (state == ST_FINISH);

`ifdef MAZE_LOADER_OPEN_CHECK_EN
    logic open_flag;
    logic err_q;
    logic entry_wall;
    logic exit_wall;

    assign entry_wall = (row == '0) && (in_data[0] == CELL_WALL);
    assign exit_wall  = last_row && (in_data[COLS-1] == CELL_WALL);

    // Open-cell check: flag a walled entry/exit as rows arrive, publish it as a sticky error entering FINISH.
    always_ff @(posedge clk) begin
        if (rst) begin
            open_flag <= 1'b0;
            err_q     <= 1'b0;
        end else if (start_ok) begin
            open_flag <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (take && (entry_wall || exit_wall)) begin
                open_flag <= 1'b1;
            end
            if (in_write && last_col && last_row && open_flag) begin
                err_q <= 1'b1;
            end
        end
    end

    assign solve_start = (state == ST_FINISH) && !open_flag;
    assign load_err    = err_q;
`else
    assign solve_start = (state == ST_FINISH);
    assign load_err    = 1'b0;
`endif

endmodule
